// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding core load/store port to APB master, with watchdog abort
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic                  cpu_err,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic                  pready,
  input  logic                  perr
);
  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic [WW-1:0] wd;
  // IDLE/SETUP/ACCESS sequencer; every output is a flop updated here
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      cpu_busy  <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      paddr     <= '0;
      pdata     <= '0;
      pstb      <= '0;
      cpu_rdata <= '0;
      wd        <= '0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      case (state)
        IDLE: if (cpu_req) begin
          state    <= SETUP;
          psel     <= 1'b1;
          cpu_busy <= 1'b1;
          paddr    <= cpu_addr;
          pdata    <= cpu_wdata;
          pwrite   <= cpu_we;
          pstb     <= cpu_we ? cpu_wstrb : 4'hF;
          wd       <= '0;
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: if (pready) begin
          state    <= IDLE;
          psel     <= 1'b0;
          penable  <= 1'b0;
          cpu_busy <= 1'b0;
          cpu_done <= 1'b1;
          cpu_err  <= perr;
          if (!pwrite) cpu_rdata <= prdata;
        end else if (TIMEOUT != 0 && wd == WD_LAST) begin
          state     <= IDLE;
          psel      <= 1'b0;
          penable   <= 1'b0;
          cpu_busy  <= 1'b0;
          cpu_done  <= 1'b1;
          cpu_err   <= 1'b1;
          cpu_rdata <= '0;
        end else begin
          wd <= wd + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: table-driven and randomized check of the APB master bridge against a transfer-level model
module tb_apb_master_bridge;
  localparam int TMO = 8;
  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic        cpu_busy, cpu_done, cpu_err;
  logic [31:0] cpu_rdata, paddr, pdata;
  logic [31:0] prdata = '0;
  logic        psel, penable, pwrite;
  logic [3:0]  pstb;
  logic        pready = 1'b0;
  logic        perr = 1'b0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .paddr(paddr), .pdata(pdata), .prdata(prdata), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pstb(pstb), .pready(pready), .perr(perr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  string cur = "";
  logic [31:0] model_rdata = '0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        err_in;
    logic [31:0] rd;
    logic        exp_err;
    int          exp_acc;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %h expected %h", cur, nm, act, exp);
    end
  endtask

  // Issue one transfer starting at a negedge with the bridge idle; act as the APB slave;
  // return at the negedge where cpu_done should be high.
  task automatic xfer(input vec_t v);
    int acc;
    logic stable;
    logic tmo;
    logic [3:0] exp_stb;
    logic [31:0] exp_rd;
    acc = 0;
    stable = 1'b1;
    tmo = v.waits >= TMO;
    exp_stb = v.we ? v.strb : 4'hF;
    exp_rd = tmo ? 32'h0 : (v.we ? model_rdata : v.rd);
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_wstrb = v.strb;
    pready = 1'($urandom); perr = 1'($urandom);
    @(negedge pclk);
    cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
    cpu_wstrb = 4'($urandom);
    chk("setup_psel", 32'(psel), 1);
    chk("setup_penable", 32'(penable), 0);
    chk("setup_busy", 32'(cpu_busy), 1);
    chk("setup_paddr", paddr, v.addr);
    chk("setup_pdata", pdata, v.wdata);
    chk("setup_pwrite", 32'(pwrite), 32'(v.we));
    chk("setup_pstb", 32'(pstb), 32'(exp_stb));
    pready = 1'($urandom); perr = 1'($urandom); prdata = $urandom;
    @(negedge pclk);
    while (penable && acc < 4 * TMO) begin
      acc++;
      if (!psel || paddr !== v.addr || pdata !== v.wdata || pstb !== exp_stb || pwrite !== v.we || cpu_done)
        stable = 1'b0;
      pready = acc > v.waits;
      perr = pready ? v.err_in : 1'($urandom);
      prdata = pready ? v.rd : $urandom;
      cpu_req = 1'($urandom);
      @(negedge pclk);
    end
    cpu_req = 1'b0; pready = 1'b0; perr = 1'b0;
    chk("access_cycles", 32'(acc), 32'(v.exp_acc));
    chk("access_stable", 32'(stable), 1);
    chk("done", 32'(cpu_done), 1);
    chk("err", 32'(cpu_err), 32'(v.exp_err));
    chk("rdata", cpu_rdata, exp_rd);
    chk("end_busy", 32'(cpu_busy), 0);
    chk("end_psel", 32'(psel), 0);
    chk("end_penable", 32'(penable), 0);
    model_rdata = exp_rd;
  endtask

  task automatic idle_check();
    @(negedge pclk);
    chk("pulse_done", 32'(cpu_done), 0);
    chk("idle_busy", 32'(cpu_busy), 0);
    chk("idle_psel", 32'(psel), 0);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 4'b0011, 0,  1'b0, 32'h0,        1'b0, 1};
    tbl[1] = '{1'b0, 32'h20,  32'h0,        4'b0000, 4,  1'b0, 32'h12345678, 1'b0, 5};
    tbl[2] = '{1'b1, 32'h400, 32'h41,       4'b0001, 0,  1'b1, 32'h0,        1'b1, 1};
    tbl[3] = '{1'b0, 32'h30,  32'h0,        4'b0101, 20, 1'b0, 32'hFFFF0000, 1'b1, 8};
    tbl[4] = '{1'b0, 32'h44,  32'h0,        4'b0000, 7,  1'b1, 32'hA5A5C3C3, 1'b1, 8};
    tbl[5] = '{1'b1, 32'h48,  32'hCAFEF00D, 4'b1100, 8,  1'b0, 32'h0,        1'b1, 8};
    tbl[6] = '{1'b0, 32'h4C,  32'h0,        4'b1010, 2,  1'b0, 32'h87654321, 1'b0, 3};
    @(negedge pclk);
    @(negedge pclk);
    cur = "reset";
    chk("psel", 32'(psel), 0);
    chk("penable", 32'(penable), 0);
    chk("pwrite", 32'(pwrite), 0);
    chk("busy", 32'(cpu_busy), 0);
    chk("done", 32'(cpu_done), 0);
    chk("err", 32'(cpu_err), 0);
    chk("paddr", paddr, 0);
    chk("pdata", pdata, 0);
    chk("pstb", 32'(pstb), 0);
    chk("rdata", cpu_rdata, 0);
    presetn = 1'b1;
    @(negedge pclk);
    for (int i = 0; i < 7; i++) begin
      cur = $sformatf("vec%0d", i);
      xfer(tbl[i]);
      idle_check();
    end
    cur = "b2b";
    v = '{1'b0, 32'h60, 32'h0, 4'h0, 1, 1'b0, 32'h11112222, 1'b0, 2};
    xfer(v);
    v = '{1'b0, 32'h64, 32'h0, 4'h0, 0, 1'b0, 32'h33334444, 1'b0, 1};
    xfer(v);
    idle_check();
    cur = "reset_in_access";
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50;
    @(negedge pclk);
    cpu_req = 1'b0;
    @(negedge pclk);
    chk("in_access", 32'(penable), 1);
    pready = 1'b0;
    presetn = 1'b0;
    @(negedge pclk);
    chk("psel", 32'(psel), 0);
    chk("penable", 32'(penable), 0);
    chk("busy", 32'(cpu_busy), 0);
    chk("done", 32'(cpu_done), 0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("done_after", 32'(cpu_done), 0);
    chk("rdata", cpu_rdata, 0);
    model_rdata = '0;
    for (int i = 0; i < 60; i++) begin
      cur = $sformatf("rnd%0d", i);
      v.we = 1'($urandom);
      v.addr = $urandom;
      v.wdata = $urandom;
      v.strb = 4'($urandom);
      v.waits = $urandom_range(0, 11);
      v.err_in = ($urandom_range(0, 3) == 0);
      v.rd = $urandom;
      v.exp_err = (v.waits >= TMO) ? 1'b1 : v.err_in;
      v.exp_acc = (v.waits >= TMO) ? TMO : v.waits + 1;
      xfer(v);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
